// File: rtl/kcpsmx3_inc.sv
// Purpose : shared types and constants for the KCPSMx instruction-fetch slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: program-memory geometry (CODE_DEPTH), the instruction word type,
// the reset/interrupt vectors, the bubble instruction, and the pc-select helper
// used by the pc register's priority mux.
package kcpsmx3_inc;

    localparam int CODE_DEPTH  = 10;
    localparam int INSTR_WIDTH = 18;

    typedef logic [INSTR_WIDTH-1:0] instr_t;
    typedef logic [CODE_DEPTH-1:0]  code_addr_t;

    localparam code_addr_t RESET_VECTOR     = 10'h000;
    localparam code_addr_t INTERRUPT_VECTOR = 10'h3FF;
    // All-zero word; decode treats it as a no-op, so bubbles are harmless.
    localparam instr_t     NOP_INSTR        = '0;

    // Source of the next pc value, in descending priority order.
    typedef enum logic [1:0] {
        PC_SEL_VECTOR   = 2'd0,
        PC_SEL_REDIRECT = 2'd1,
        PC_SEL_HOLD     = 2'd2,
        PC_SEL_INC      = 2'd3
    } pc_sel_e;

    // Interrupt beats redirect beats stall beats sequential advance.
    function automatic pc_sel_e pc_select(input logic stall,
                                          input logic redirect,
                                          input logic interrupt_take);
        pc_sel_e sel;
        if (interrupt_take) begin
            sel = PC_SEL_VECTOR;
        end else if (redirect) begin
            sel = PC_SEL_REDIRECT;
        end else if (stall) begin
            sel = PC_SEL_HOLD;
        end else begin
            sel = PC_SEL_INC;
        end
        return sel;
    endfunction

    // Sequential successor; wraps silently at the top of program memory.
    function automatic code_addr_t pc_increment(input code_addr_t pc);
        return pc + code_addr_t'(1);
    endfunction

endpackage

// File: rtl/kcpsmx_pc.sv
// Purpose : program counter register with interrupt/redirect/stall priority mux.
// Latency : next value visible one clock after the controlling inputs.
// Backpressure: stall holds the pc unless a redirect or interrupt overrides it.
//
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   stall             - hold the pc (ignored when redirect/interrupt_take)
//   redirect          - load redirect_address
//   redirect_address  - branch/call/return target
//   interrupt_take    - load INTERRUPT_VECTOR (highest priority)
//   pc                - current fetch address
module kcpsmx_pc
    import kcpsmx3_inc::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [CODE_DEPTH-1:0] redirect_address,
    input  logic                  interrupt_take,
    output logic [CODE_DEPTH-1:0] pc
);

    pc_sel_e                 pc_sel;
    logic [CODE_DEPTH-1:0]   pc_next;

    always_comb begin
        pc_sel  = pc_select(stall, redirect, interrupt_take);
        pc_next = pc;
        case (pc_sel)
            PC_SEL_VECTOR:   pc_next = INTERRUPT_VECTOR;
            PC_SEL_REDIRECT: pc_next = redirect_address;
            PC_SEL_HOLD:     pc_next = pc;
            PC_SEL_INC:      pc_next = pc_increment(pc);
            default:         pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/kcpsmx_ifu.sv
// Purpose : instruction fetch unit; drives program memory and the IF/ID register.
// Latency : address issued in cycle n reaches id_* in cycle n+2; redirect costs 2 bubbles.
// Backpressure: stall freezes pc, fetch tracking and IF/ID and gates the memory read.
//
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   code_address      - program-memory read address (the pc)
//   code_enable       - program-memory read enable; memory output holds when low
//   instruction_in    - program-memory data, valid one cycle after an enabled read
//   stall             - downstream cannot accept this cycle
//   redirect          - taken jump/call/return; redirect_address is the target
//   interrupt_take    - interrupt accepted; fetch restarts at INTERRUPT_VECTOR
//   id_instruction    - IF/ID instruction register
//   id_pc             - address of id_instruction
//   id_valid          - id_instruction is live (0 = bubble)
//   interrupt_return  - address to push on interrupt entry
module kcpsmx_ifu
    import kcpsmx3_inc::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic [CODE_DEPTH-1:0] code_address,
    output logic                  code_enable,
    input  instr_t                instruction_in,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [CODE_DEPTH-1:0] redirect_address,
    input  logic                  interrupt_take,
    output instr_t                id_instruction,
    output logic [CODE_DEPTH-1:0] id_pc,
    output logic                  id_valid,
    output logic [CODE_DEPTH-1:0] interrupt_return
);

    logic [CODE_DEPTH-1:0] pc;
    logic [CODE_DEPTH-1:0] fetch_pc_q;     // address of the read whose data lands next cycle
    logic                  fetch_valid_q;  // that read is on the correct path
    logic                  kill;
    logic                  advance;
    logic [CODE_DEPTH-1:0] interrupt_return_next;

    kcpsmx_pc u_pc (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_address (redirect_address),
        .interrupt_take   (interrupt_take),
        .pc               (pc)
    );

    // A kill discards both the in-flight read and the IF/ID contents, and it
    // overrides stall so the new path starts fetching immediately.
    assign kill    = redirect | interrupt_take;
    assign advance = !stall && !kill;

    assign code_address = pc;
    // The read issued during a kill cycle is on the wrong path; it is still
    // enabled (memory is idle otherwise) but fetch_valid_q marks it dead.
    assign code_enable  = !reset && (!stall || kill);

    // Return address is the oldest instruction that has not yet executed.
    // With a coincident redirect the branch target is where execution resumes.
    always_comb begin
        interrupt_return_next = interrupt_return;
        if (interrupt_take) begin
            if (redirect) begin
                interrupt_return_next = redirect_address;
            end else if (id_valid) begin
                interrupt_return_next = id_pc;
            end else if (fetch_valid_q) begin
                interrupt_return_next = fetch_pc_q;
            end else begin
                interrupt_return_next = pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
        end else if (kill) begin
            fetch_valid_q <= 1'b0;
        end else if (advance) begin
            fetch_pc_q    <= pc;
            fetch_valid_q <= 1'b1;
        end
    end

    // id_pc is left alone on a kill; it is only meaningful while id_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instruction <= NOP_INSTR;
            id_pc          <= RESET_VECTOR;
            id_valid       <= 1'b0;
        end else if (kill) begin
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else if (advance) begin
            id_instruction <= instruction_in;
            id_pc          <= fetch_pc_q;
            id_valid       <= fetch_valid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interrupt_return <= RESET_VECTOR;
        end else begin
            interrupt_return <= interrupt_return_next;
        end
    end

endmodule

// File: tb/tb_kcpsmx_ifu.sv
// Purpose : self-checking bench for kcpsmx_ifu (directed table, corner sequences, random vs model).
// Latency : n/a.
// Backpressure: n/a.
module tb_kcpsmx_ifu;
    import kcpsmx3_inc::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [CODE_DEPTH-1:0] code_address;
    logic                  code_enable;
    instr_t                instruction_in = '0;
    logic                  stall = 1'b0;
    logic                  redirect = 1'b0;
    logic [CODE_DEPTH-1:0] redirect_address = '0;
    logic                  interrupt_take = 1'b0;
    instr_t                id_instruction;
    logic [CODE_DEPTH-1:0] id_pc;
    logic                  id_valid;
    logic [CODE_DEPTH-1:0] interrupt_return;

    int errors = 0;
    int checks = 0;

    kcpsmx_ifu dut (
        .clk              (clk),
        .reset            (reset),
        .code_address     (code_address),
        .code_enable      (code_enable),
        .instruction_in   (instruction_in),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_address (redirect_address),
        .interrupt_take   (interrupt_take),
        .id_instruction   (id_instruction),
        .id_pc            (id_pc),
        .id_valid         (id_valid),
        .interrupt_return (interrupt_return)
    );

    always #5 clk = ~clk;

    // Memory contents: address in the low bits, inverted address byte on top.
    function automatic instr_t mem_fn(input int a);
        logic [9:0] a10;
        a10 = a[9:0];
        return instr_t'({~a10[7:0], a10});
    endfunction

    // Synchronous-read program memory that holds its output when not enabled.
    always @(posedge clk) begin
        if (code_enable) instruction_in <= mem_fn(int'(code_address));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " code_address"},     32'(code_address), 32'h0);
        check({tag, " code_enable"},      32'(code_enable), 32'h0);
        check({tag, " id_valid"},         32'(id_valid), 32'h0);
        check({tag, " id_pc"},            32'(id_pc), 32'h0);
        check({tag, " id_instruction"},   32'(id_instruction), 32'h0);
        check({tag, " interrupt_return"}, 32'(interrupt_return), 32'h0);
    endtask

    // Leaves the bench at posedge+1 of the first cycle after reset release.
    task automatic do_reset();
        stall = 1'b0; redirect = 1'b0; interrupt_take = 1'b0; redirect_address = '0;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       s, r, i;
        logic [9:0] ra;
        logic [9:0] ca;
        logic       ce;
        logic       vld;
        logic [9:0] idpc;
        logic [9:0] ret;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic i, input logic [9:0] ra,
                                input logic [9:0] ca, input logic ce, input logic vld,
                                input logic [9:0] idpc, input logic [9:0] ret);
        vec_t v;
        v.s = s; v.r = r; v.i = i; v.ra = ra; v.ca = ca; v.ce = ce;
        v.vld = vld; v.idpc = idpc; v.ret = ret;
        return v;
    endfunction

    // Reference model state: a two-slot delay line of fetched addresses
    // (slot 0 = decode, slot 1 = memory read in flight), -1 marks a bubble.
    int m_pc;
    int m_stage[2];
    int m_ret;
    bit m_nop;

    initial begin
        vec_t tbl[$];

        // Each row: inputs for one cycle and the outputs expected in that cycle.
        //            s  r  i  ra      ca      ce vld idpc    ret
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h000, 1, 0, 10'h0,   10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h001, 1, 0, 10'h0,   10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h002, 1, 1, 10'h000, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h003, 1, 1, 10'h001, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h004, 1, 1, 10'h002, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h005, 1, 1, 10'h003, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h006, 1, 1, 10'h004, 10'h0));
        tbl.push_back(mk(1, 0, 0, 10'h0,   10'h007, 0, 1, 10'h005, 10'h0));
        tbl.push_back(mk(1, 0, 0, 10'h0,   10'h007, 0, 1, 10'h005, 10'h0));
        tbl.push_back(mk(1, 0, 0, 10'h0,   10'h007, 0, 1, 10'h005, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h007, 1, 1, 10'h005, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h008, 1, 1, 10'h006, 10'h0));
        tbl.push_back(mk(0, 1, 0, 10'h120, 10'h009, 1, 1, 10'h007, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h120, 1, 0, 10'h0,   10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h121, 1, 0, 10'h0,   10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h122, 1, 1, 10'h120, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h123, 1, 1, 10'h121, 10'h0));
        tbl.push_back(mk(0, 0, 1, 10'h0,   10'h124, 1, 1, 10'h122, 10'h0));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h3FF, 1, 0, 10'h0,   10'h122));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h000, 1, 0, 10'h0,   10'h122));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h001, 1, 1, 10'h3FF, 10'h122));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h002, 1, 1, 10'h000, 10'h122));
        tbl.push_back(mk(1, 1, 1, 10'h200, 10'h003, 1, 1, 10'h001, 10'h122));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h3FF, 1, 0, 10'h0,   10'h200));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h000, 1, 0, 10'h0,   10'h200));
        tbl.push_back(mk(0, 0, 0, 10'h0,   10'h001, 1, 1, 10'h3FF, 10'h200));

        do_reset();

        // ---------------- directed table ----------------
        foreach (tbl[k]) begin
            stall = tbl[k].s; redirect = tbl[k].r; interrupt_take = tbl[k].i;
            redirect_address = tbl[k].ra;
            #1;
            check($sformatf("tbl%0d code_address", k), 32'(code_address), 32'(tbl[k].ca));
            check($sformatf("tbl%0d code_enable", k),  32'(code_enable),  32'(tbl[k].ce));
            check($sformatf("tbl%0d id_valid", k),     32'(id_valid),     32'(tbl[k].vld));
            check($sformatf("tbl%0d interrupt_return", k), 32'(interrupt_return), 32'(tbl[k].ret));
            if (tbl[k].vld) begin
                check($sformatf("tbl%0d id_pc", k), 32'(id_pc), 32'(tbl[k].idpc));
                check($sformatf("tbl%0d id_instruction", k), 32'(id_instruction),
                      32'(mem_fn(int'(tbl[k].idpc))));
            end else if (k > 0 && (tbl[k-1].r || tbl[k-1].i)) begin
                check($sformatf("tbl%0d id_instruction nop", k), 32'(id_instruction), 32'(NOP_INSTR));
            end
            tick();
            stall = 1'b0; redirect = 1'b0; interrupt_take = 1'b0;
        end

        // ---------------- interrupt taken at id_pc=0x044 ----------------
        redirect = 1'b1; redirect_address = 10'h044;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        check("irq id_valid before", 32'(id_valid), 32'h1);
        check("irq id_pc before",    32'(id_pc),    32'h044);
        interrupt_take = 1'b1;
        tick();
        interrupt_take = 1'b0;
        check("irq interrupt_return", 32'(interrupt_return), 32'h044);
        check("irq code_address",     32'(code_address),     32'h3FF);
        check("irq bubble1",          32'(id_valid),         32'h0);
        check("irq nop",              32'(id_instruction),   32'(NOP_INSTR));
        tick();
        check("irq bubble2",          32'(id_valid),         32'h0);
        tick();
        check("irq vector valid",     32'(id_valid),         32'h1);
        check("irq vector id_pc",     32'(id_pc),            32'h3FF);
        tick();
        check("irq wrap id_pc",       32'(id_pc),            32'h000);
        check("irq wrap instr",       32'(id_instruction),   32'(mem_fn(0)));

        // ---------------- reset pulse during a stall at id_pc=0x0AA ----------------
        redirect = 1'b1; redirect_address = 10'h0AA;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        check("rst id_pc before", 32'(id_pc), 32'h0AA);
        stall = 1'b1;
        tick();
        tick();
        check("rst stall id_pc",  32'(id_pc),        32'h0AA);
        check("rst stall ca",     32'(code_address), 32'h0AC);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst async");
        stall = 1'b0;
        tick();
        check_reset_outputs("rst held");
        reset = 1'b0;
        #1;
        check("rst restart ca", 32'(code_address), 32'h000);
        check("rst restart ce", 32'(code_enable),  32'h1);
        tick();
        check("rst restart bubble", 32'(id_valid), 32'h0);
        tick();
        check("rst restart valid", 32'(id_valid), 32'h1);
        check("rst restart id_pc", 32'(id_pc),    32'h000);

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        m_pc = 0; m_stage[0] = -1; m_stage[1] = -1; m_ret = 0; m_nop = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            stall            = ($urandom_range(0, 99) < 30);
            redirect         = ($urandom_range(0, 99) < 8);
            interrupt_take   = ($urandom_range(0, 99) < 4);
            redirect_address = 10'($urandom);
            #1;
            check("rnd code_address", 32'(code_address), 32'(m_pc));
            check("rnd code_enable",  32'(code_enable),
                  32'(!stall || redirect || interrupt_take));
            check("rnd id_valid", 32'(id_valid), 32'(m_stage[0] >= 0));
            check("rnd interrupt_return", 32'(interrupt_return), 32'(m_ret));
            if (m_stage[0] >= 0) begin
                check("rnd id_pc",          32'(id_pc),          32'(m_stage[0]));
                check("rnd id_instruction", 32'(id_instruction), 32'(mem_fn(m_stage[0])));
            end else if (m_nop) begin
                check("rnd id_instruction nop", 32'(id_instruction), 32'(NOP_INSTR));
            end

            if (interrupt_take) begin
                if (redirect)              m_ret = int'(redirect_address);
                else if (m_stage[0] >= 0)  m_ret = m_stage[0];
                else if (m_stage[1] >= 0)  m_ret = m_stage[1];
                else                       m_ret = m_pc;
            end
            if (redirect || interrupt_take) begin
                m_stage[0] = -1;
                m_stage[1] = -1;
                m_pc  = interrupt_take ? 1023 : int'(redirect_address);
                m_nop = 1'b1;
            end else if (!stall) begin
                m_stage[0] = m_stage[1];
                m_stage[1] = m_pc;
                m_pc  = (m_pc + 1) % 1024;
                m_nop = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
